// File: rtl/clause_stream_reader_pkg.sv
// rtl/clause_stream_reader_pkg.sv - shared clause-datapath definitions
// Contents: FSM state encoding of the burst reader, depth of the output
// buffer, and the read-credit helper used to decide when a BRAM read may issue.
package clause_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [2:0] FIFO_DEPTH = 3'd2;

  // A read may issue when the words that will still be buffered after this
  // cycle's pop, plus the read already in flight, leave a free slot.
  // Counting the concurrent pop is what allows one word per cycle when
  // the consumer is always ready.
  function automatic logic credit_ok(input logic [1:0] buffered,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, buffered} + {2'b00, inflight} - {2'b00, pop};
    return pending < FIFO_DEPTH;
  endfunction

endpackage

// File: rtl/clause_skid_fifo.sv
// rtl/clause_skid_fifo.sv - two-entry output buffer for clause words
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push, wdata     write one entry (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   rdata           head entry; only changes on pop or on push into empty
//   valid           buffer non-empty
//   count           occupancy 0..2
module clause_skid_fifo
  import clause_stream_reader_pkg::*;
#(
  parameter int WIDTH = 257
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = ({1'b0, cnt} >= FIFO_DEPTH);
  assign valid   = (cnt != 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;
  assign rdata   = head;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) head <= wdata;
          else             tail <= wdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word goes behind whatever remains
          if (cnt == 2'd1) begin
            head <= wdata;
          end else begin
            head <= tail;
            tail <= wdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/clause_stream_reader.sv
// rtl/clause_stream_reader.sv - burst reader from clause BRAM to a ready/valid stream
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   start, base_addr,        burst request; address and length captured in IDLE
//   num_words
//   busy, done               burst in progress / one-cycle completion pulse
//   enb, addrb, doutb        clause BRAM read port (one-cycle read latency)
//   m_valid, m_ready,        output word stream, m_last on final word
//   m_data, m_last
module clause_stream_reader
  import clause_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic                  zero_done;

  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  pop;
  logic                  issue;
  logic                  last_out;

  assign pop      = fifo_valid && m_ready;
  assign issue    = (state == ST_RUN) && credit_ok(fifo_count, inflight, pop);
  assign last_out = fifo_rdata[DATA_WIDTH];

  assign busy    = (state != ST_IDLE);
  assign done    = zero_done || ((state == ST_DRAIN) && pop && last_out);
  assign enb     = issue;
  assign addrb   = rd_addr;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_rdata[DATA_WIDTH-1:0];
  // the stale head keeps its flag after the final pop, so gate with valid
  assign m_last  = fifo_valid && last_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      rd_addr       <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      zero_done     <= 1'b0;
    end else begin
      zero_done     <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == REM_ONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              state     <= ST_RUN;
              rd_addr   <= base_addr;
              remaining <= num_words;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            rd_addr   <= rd_addr + ADDR_WIDTH'(1);
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && last_out) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // read data lands one cycle after enb; the in-flight flag is cleared by
  // reset so a word returning just after reset is dropped
  clause_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .wdata ({inflight_last, doutb}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_clause_stream_reader.sv
// tb/tb_clause_stream_reader.sv - scoreboard bench for clause_stream_reader
module tb_clause_stream_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [9:0]   base_addr;
  logic [10:0]  num_words;
  logic         busy;
  logic         done;
  logic         enb;
  logic [9:0]   addrb;
  logic [255:0] doutb;
  logic         m_valid;
  logic         m_ready;
  logic [255:0] m_data;
  logic         m_last;

  always #5 clk = ~clk;

  clause_stream_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  typedef struct {
    logic [255:0] data;
    logic         last;
  } exp_t;

  logic [255:0] mem [0:1023];
  exp_t         exp_q[$];
  int           addr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int zero_due_cyc = -1;
  int issued = 0;
  int xfer = 0;
  int done_count = 0;
  int done_cyc = -1;
  int done_ref = 0;
  int st_cyc = 0;
  bit rand_ready = 0;

  logic         stall_prev = 1'b0;
  logic [255:0] held_data = '0;
  logic         held_last = 1'b0;
  exp_t         e;
  logic         exp_done;
  int           a;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // clause BRAM: one-cycle registered read; junk on the bus when idle
  always @(posedge clk) begin
    if (enb) doutb <= mem[addrb];
    else     doutb <= rand256();
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      addr_q.delete();
      issued = 0;
      xfer = 0;
      stall_prev = 1'b0;
    end else begin
      exp_done = (cyc == zero_due_cyc);
      if (enb) begin
        if (addr_q.size() == 0) fail_event("unexpected_enb");
        else begin
          a = addr_q.pop_front();
          chk("addrb", 256'(addrb), 256'(a));
        end
        issued++;
      end
      if (m_valid && stall_prev) begin
        chk("stall_data_stable", m_data, held_data);
        chk("stall_last_stable", 256'(m_last), 256'(held_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail_event("unexpected_word");
        else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", 256'(m_last), 256'(e.last));
          if (e.last) exp_done = 1'b1;
        end
        xfer++;
      end
      chk("occupancy_le_2", 256'((issued - xfer) <= 2), 256'(1));
      chk("done", 256'(done), 256'(exp_done));
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
    end
  end

  task automatic start_burst(input logic [9:0] base, input int num, input bit lat);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    num_words = 11'(num);
    st_cyc    = cyc;
    done_ref  = done_count;
    if (num == 0) zero_due_cyc = cyc + 1;
    for (int k = 0; k < num; k++) begin
      exp_q.push_back('{data: mem[(int'(base) + k) % 1024], last: (k == num - 1)});
      addr_q.push_back((int'(base) + k) % 1024);
    end
    if (lat) begin
      @(negedge clk);
      chk("busy_start_cycle", 256'(busy), 256'(0));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("busy_first_run", 256'(busy), 256'(1));
      chk("enb_first_run", 256'(enb), 256'(1));
      chk("m_valid_c1", 256'(m_valid), 256'(0));
      @(negedge clk);
      chk("m_valid_c2", 256'(m_valid), 256'(0));
      @(negedge clk);
      chk("m_valid_c3", 256'(m_valid), 256'(1));
    end
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (done_count == done_ref && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_count == done_ref) begin
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", max_cycles);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_enb"}, 256'(enb), 256'(0));
    chk({tag, "_m_valid"}, 256'(m_valid), 256'(0));
    chk({tag, "_m_last"}, 256'(m_last), 256'(0));
    chk({tag, "_addrb"}, 256'(addrb), 256'(0));
    chk({tag, "_m_data"}, m_data, 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int x0;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = rand256();
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // straight burst, consumer always ready: latency and throughput
    start_burst(10'h010, 4, 1);
    wait_done(50);
    chk("done_cycle_num4", 256'(done_cyc), 256'(st_cyc + 4 + 2));
    @(negedge clk);
    chk("busy_after_done", 256'(busy), 256'(0));

    // address wrap
    start_burst(10'h3FE, 4, 0);
    wait_done(50);

    // zero-length request
    start_burst(10'h123, 0, 0);
    @(negedge clk);
    chk("zero_done_pulse", 256'(done), 256'(1));
    chk("zero_busy", 256'(busy), 256'(0));
    repeat (4) @(posedge clk);

    // start while busy must be ignored
    start_burst(10'h100, 6, 0);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 10'h200;
    num_words = 11'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(50);
    repeat (3) @(posedge clk);

    // reset in the middle of a burst
    x0 = xfer;
    d0 = done_count;
    start_burst(10'h050, 6, 0);
    n = 0;
    while (xfer - x0 < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (5) @(posedge clk);
    chk("midreset_no_done", 256'(done_count), 256'(d0));
    start_burst(10'h3F0, 5, 1);
    wait_done(50);

    // randomized backpressure
    rand_ready = 1;
    start_burst(10'($urandom_range(0, 1023)), 8, 0);
    wait_done(400);
    for (int b = 0; b < 8; b++) begin
      start_burst(10'($urandom_range(0, 1023)), int'($urandom_range(0, 16)), 0);
      wait_done(400);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rand_ready = 0;
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    chk("addr_queue_empty", 256'(addr_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
